// File: rtl/mips_chk_pkg.sv
// Shared types and defaults for the MIPS store checker.
package mips_chk_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] CHK_ADDR_DEF   = 32'd84;
    localparam logic [DATA_W-1:0] CHK_EXPECT_DEF = 32'h0010_0119;

    typedef enum logic [1:0] {
        CHK_RUN     = 2'd0,
        CHK_PASS    = 2'd1,
        CHK_FAIL    = 2'd2,
        CHK_TIMEOUT = 2'd3
    } chk_state_e;

    // One store-log entry: address in the upper half, data in the lower half.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } log_entry_t;

endpackage

// File: rtl/store_log_fifo.sv
// Show-ahead FIFO holding accepted stores until the host drains them.
module store_log_fifo
    import mips_chk_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  log_entry_t i_entry,
    input  logic       i_pop,
    output log_entry_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;

    log_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_full;
    logic             r_empty;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_nxt;

    // A push into a full FIFO is allowed only when the head leaves on the same edge.
    always_comb begin
        w_pop_ok  = i_pop && !r_empty;
        w_push_ok = i_push && (!r_full || w_pop_ok);
        w_wr_nxt  = r_wr_ptr + PTR_W'(w_push_ok);
        w_rd_nxt  = r_rd_ptr + PTR_W'(w_pop_ok);
    end

    // Pointers plus registered full/empty flags derived from the next pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_empty  <= (w_wr_nxt == w_rd_nxt);
            r_full   <= (w_wr_nxt[IDX_W-1:0] == w_rd_nxt[IDX_W-1:0]) &&
                        (w_wr_nxt[IDX_W] != w_rd_nxt[IDX_W]);
        end
    end

    // Storage array; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[IDX_W-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/store_checker.sv
// Watches core stores, logs them, and decides pass/fail/timeout for the run.
module store_checker
    import mips_chk_pkg::*;
#(
    parameter logic [31:0] CHECK_ADDR     = CHK_ADDR_DEF,
    parameter logic [31:0] EXPECT_DATA    = CHK_EXPECT_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataaddr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [15:0] store_count,
    output logic        overflow
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    chk_state_e       r_state;
    chk_state_e       w_state_nxt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [15:0]      r_store_count;
    logic             r_overflow;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic             r_done;

    logic             w_accept;
    logic             w_is_check;
    logic             w_tmo_hit;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    log_entry_t       w_entry;
    log_entry_t       w_head;

    // Store qualification and timeout expiry for this edge.
    always_comb begin
        w_accept      = memwrite && (r_state == CHK_RUN);
        w_is_check    = w_accept && (dataaddr == CHECK_ADDR);
        w_tmo_hit     = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        w_pop         = log_ready && !w_empty;
        w_entry.addr  = dataaddr;
        w_entry.data  = writedata;
    end

    // Next-state: a check store beats a same-edge timeout; terminal states hold.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            CHK_RUN: begin
                if (w_is_check) begin
                    w_state_nxt = (writedata == EXPECT_DATA) ? CHK_PASS : CHK_FAIL;
                end else if (w_tmo_hit) begin
                    w_state_nxt = CHK_TIMEOUT;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // State register with registered status outputs decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CHK_RUN;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pass    <= (w_state_nxt == CHK_PASS);
            r_fail    <= (w_state_nxt == CHK_FAIL);
            r_timeout <= (w_state_nxt == CHK_TIMEOUT);
            r_done    <= (w_state_nxt != CHK_RUN);
        end
    end

    // Timeout counter: counts edges spent in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == CHK_RUN) && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Saturating count of accepted stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store_count <= '0;
        end else if (w_accept && (r_store_count != 16'hFFFF)) begin
            r_store_count <= r_store_count + 16'd1;
        end
    end

    // Sticky drop flag: an accepted store found the log full with no pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_accept && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    store_log_fifo #(
        .DEPTH   (LOG_DEPTH)
    ) u_log (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_entry (w_entry),
        .i_pop   (log_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign store_count = r_store_count;
    assign overflow    = r_overflow;
    assign log_valid   = !w_empty;
    assign log_addr    = w_head.addr;
    assign log_data    = w_head.data;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: directed scenarios plus randomized runs against a queue model.
module tb_store_checker;

    localparam int          T_CYC = 20;
    localparam int          DEPTH = 4;
    localparam logic [31:0] CA    = 32'd84;
    localparam logic [31:0] EX    = 32'h0010_0119;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [15:0] store_count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: status 0=run 1=pass 2=fail 3=timeout.
    int          m_status;
    int          m_edges;
    logic [63:0] m_log [$];
    int          m_count;
    bit          m_ovf;

    store_checker #(
        .CHECK_ADDR     (CA),
        .EXPECT_DATA    (EX),
        .TIMEOUT_CYCLES (T_CYC),
        .LOG_DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataaddr    (dataaddr),
        .writedata   (writedata),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .store_count (store_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_status = 0;
        m_edges  = 0;
        m_log.delete();
        m_count  = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        if (rdy && m_log.size() > 0) void'(m_log.pop_front());
        if (m_status == 0) begin
            m_edges++;
            if (mw) begin
                if (m_count < 65535) m_count++;
                if (m_log.size() < DEPTH) m_log.push_back({a, d});
                else m_ovf = 1'b1;
                if (a == CA) m_status = (d == EX) ? 1 : 2;
            end
            if (m_status == 0 && m_edges == T_CYC) m_status = 3;
        end
    endtask

    // One clock: drive at negedge, model updates at posedge, return at next negedge.
    task automatic cyc(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        memwrite  = mw;
        dataaddr  = a;
        writedata = d;
        log_ready = rdy;
        @(posedge clk);
        model_edge(mw, a, d, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataaddr  = '0;
        writedata = '0;
        log_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataaddr  = '0;
        writedata = '0;
        log_ready = 1'b0;
        model_reset();
        @(negedge clk);
        n_tests++;
        if ({done, pass, fail, timeout, log_valid, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {done, pass, fail, timeout, log_valid, overflow});
        end
        n_tests++;
        if (store_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", store_count);
        end
        n_tests++;
        if ({log_addr, log_data} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_head: got %h want 0", {log_addr, log_data});
        end
        reset = 1'b0;
    endtask

    task automatic test_pass();
        logic [63:0] exp_e [2];
        exp_e[0] = {32'd80, 32'd5};
        exp_e[1] = {CA, EX};
        do_reset();
        cyc(1'b1, 32'd80, 32'd5, 1'b0);
        n_tests++;
        if ({done, pass} !== 2'b00) begin
            n_fail++;
            $display("FAIL pass_early: got done/pass %b want 00", {done, pass});
        end
        cyc(1'b1, CA, EX, 1'b0);
        n_tests++;
        if ({done, pass, fail, timeout} !== 4'b1100) begin
            n_fail++;
            $display("FAIL pass_flags: got %b want 1100", {done, pass, fail, timeout});
        end
        n_tests++;
        if (store_count !== 16'd2) begin
            n_fail++;
            $display("FAIL pass_count: got %0d want 2", store_count);
        end
        cyc(1'b1, 32'd88, 32'd7, 1'b0);
        n_tests++;
        if (store_count !== 16'd2) begin
            n_fail++;
            $display("FAIL terminal_ignore: got %0d want 2", store_count);
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({log_valid, log_addr, log_data} !== {1'b1, exp_e[i]}) begin
                n_fail++;
                $display("FAIL pass_drain%0d: got v=%b %h want v=1 %h", i, log_valid, {log_addr, log_data}, exp_e[i]);
            end
            cyc(1'b0, '0, '0, 1'b1);
        end
        n_tests++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_drained: got valid %b want 0", log_valid);
        end
    endtask

    task automatic test_fail();
        do_reset();
        cyc(1'b1, CA, 32'd1048856, 1'b0);
        n_tests++;
        if ({done, pass, fail} !== 3'b101) begin
            n_fail++;
            $display("FAIL fail_flags: got %b want 101", {done, pass, fail});
        end
        cyc(1'b1, CA, EX, 1'b0);
        n_tests++;
        if ({fail, pass, store_count} !== {1'b1, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL fail_sticky: got fail=%b pass=%b cnt=%0d want 1 0 1", fail, pass, store_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (T_CYC - 1) cyc(1'b0, '0, '0, 1'b0);
        n_tests++;
        if ({done, timeout} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_early: got %b want 00", {done, timeout});
        end
        cyc(1'b0, '0, '0, 1'b0);
        n_tests++;
        if ({done, pass, fail, timeout} !== 4'b1001) begin
            n_fail++;
            $display("FAIL timeout_hit: got %b want 1001", {done, pass, fail, timeout});
        end
        do_reset();
        repeat (T_CYC - 1) cyc(1'b0, '0, '0, 1'b0);
        cyc(1'b1, CA, EX, 1'b0);
        n_tests++;
        if ({done, pass, fail, timeout} !== 4'b1100) begin
            n_fail++;
            $display("FAIL timeout_vs_check: got %b want 1100", {done, pass, fail, timeout});
        end
    endtask

    task automatic test_overflow();
        logic [63:0] ent [6];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ent[i] = {32'h100 + 32'(4 * i), 32'($urandom)};
            cyc(1'b1, ent[i][63:32], ent[i][31:0], 1'b0);
        end
        n_tests++;
        if ({overflow, log_valid, store_count} !== {1'b1, 1'b1, 16'd6}) begin
            n_fail++;
            $display("FAIL ovf_state: got ovf=%b v=%b cnt=%0d want 1 1 6", overflow, log_valid, store_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if ({log_valid, log_addr, log_data} !== {1'b1, ent[i]}) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got v=%b %h want v=1 %h", i, log_valid, {log_addr, log_data}, ent[i]);
            end
            cyc(1'b0, '0, '0, 1'b1);
        end
        n_tests++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_empty: got valid %b want 0", log_valid);
        end
    endtask

    task automatic test_full_pushpop();
        logic [63:0] ent [5];
        do_reset();
        for (int i = 0; i < 5; i++) ent[i] = {32'h200 + 32'(4 * i), 32'($urandom)};
        for (int i = 0; i < 4; i++) cyc(1'b1, ent[i][63:32], ent[i][31:0], 1'b0);
        cyc(1'b1, ent[4][63:32], ent[4][31:0], 1'b1);
        n_tests++;
        if ({overflow, store_count} !== {1'b0, 16'd5}) begin
            n_fail++;
            $display("FAIL pushpop_state: got ovf=%b cnt=%0d want 0 5", overflow, store_count);
        end
        for (int i = 1; i < 5; i++) begin
            n_tests++;
            if ({log_valid, log_addr, log_data} !== {1'b1, ent[i]}) begin
                n_fail++;
                $display("FAIL pushpop_drain%0d: got v=%b %h want v=1 %h", i, log_valid, {log_addr, log_data}, ent[i]);
            end
            cyc(1'b0, '0, '0, 1'b1);
        end
        n_tests++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_empty: got valid %b want 0", log_valid);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(4 * i), 32'($urandom), 1'b0);
        n_tests++;
        if ({log_valid, store_count} !== {1'b1, 16'd3}) begin
            n_fail++;
            $display("FAIL midrun_pre: got v=%b cnt=%0d want 1 3", log_valid, store_count);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({done, pass, fail, timeout, log_valid, overflow, store_count, log_addr, log_data} !== 86'd0) begin
            n_fail++;
            $display("FAIL midrun_async: got flags=%b cnt=%0d head=%h want all 0",
                     {done, pass, fail, timeout, log_valid, overflow}, store_count, {log_addr, log_data});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, CA, EX, 1'b0);
        n_tests++;
        if ({pass, store_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL midrun_restart: got pass=%b cnt=%0d want 1 1", pass, store_count);
        end
    endtask

    task automatic test_no_write();
        do_reset();
        cyc(1'b0, CA, EX, 1'b1);
        n_tests++;
        if ({pass, done, log_valid, store_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL no_write: got pass=%b done=%b v=%b cnt=%0d want all 0", pass, done, log_valid, store_count);
        end
    endtask

    task automatic test_random();
        bit          mw;
        bit          rdy;
        int          sel;
        logic [31:0] a;
        logic [31:0] d;
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int c = 0; c < 36; c++) begin
                mw  = 1'($urandom_range(0, 1));
                sel = int'($urandom_range(0, 23));
                a   = (sel == 0) ? CA : ((sel < 6) ? 32'd80 : 32'($urandom));
                d   = ($urandom_range(0, 1) == 1) ? EX : 32'($urandom);
                rdy = ($urandom_range(0, 2) == 0);
                cyc(mw, a, d, rdy);
                n_tests++;
                if ({done, pass, fail, timeout} !== {m_status != 0, m_status == 1, m_status == 2, m_status == 3}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_%0d_status: got %b want status %0d", run, c, {done, pass, fail, timeout}, m_status);
                end
                n_tests++;
                if ({store_count, overflow, log_valid} !== {16'(m_count), m_ovf, m_log.size() != 0}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_%0d_cnt: got cnt=%0d ovf=%b v=%b want %0d %b %0d",
                             run, c, store_count, overflow, log_valid, m_count, m_ovf, m_log.size());
                end
                if (m_log.size() != 0) begin
                    n_tests++;
                    if ({log_addr, log_data} !== m_log[0]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_%0d_head: got %h want %h", run, c, {log_addr, log_data}, m_log[0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_overflow();
        test_full_pushpop();
        test_reset_midrun();
        test_no_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
